// File: rtl/shift_pkg.sv
// shift_pkg: op encoding, control bundle and widths shared by the shift_pipe datapath.
package shift_pkg;
    localparam int XLEN_DEF = 64;
    localparam int SHAMT_W = $clog2(XLEN_DEF);
    localparam int TAG_W = 4;
    typedef enum logic [2:0] {
        SHOP_SRAW, SHOP_SRLW, SHOP_SLLW, SHOP_SRL, SHOP_SLL, SHOP_SRA, SHOP_ROR, SHOP_ROL
    } shop_e;
    typedef struct packed {
        logic [TAG_W-1:0]   tag;
        logic [SHAMT_W-1:0] amt;
        logic               fill;
        logic               rot;
        logic               left;
        logic               word;
        logic               ill;
    } shctl_t;
    function automatic logic shop_is_word(shop_e op);
        return op inside {SHOP_SRAW, SHOP_SRLW, SHOP_SLLW};
    endfunction
endpackage

// File: rtl/shift_slice.sv
// shift_slice: LEVELS right-shift/rotate mux levels (amount bits FIRST upward) feeding one
// valid/ready register stage. Rotate muxes exist only when SHIFT_ROTATE_EN is defined.
module shift_slice import shift_pkg::*; #(
    parameter int XLEN   = 64,
    parameter int LEVELS = 1,
    parameter int FIRST  = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            i_valid,
    input  shctl_t          i_ctl,
    input  logic [XLEN-1:0] i_data,
    input  logic            i_nxt_ready,
    output logic            o_ready,
    output logic            o_valid,
    output shctl_t          o_ctl,
    output logic [XLEN-1:0] o_data
);
    logic            r_v;
    shctl_t          r_ctl;
    logic [XLEN-1:0] r_d;
    logic [XLEN-1:0] w_lv [LEVELS+1];

    assign w_lv[0] = i_data;
    for (genvar k = 0; k < LEVELS; k++) begin : g_lv
        localparam int S = 1 << (FIRST + k);
        logic [XLEN-1:0] w_sh;
        assign w_sh = {{S{i_ctl.fill}}, w_lv[k][XLEN-1:S]};
`ifdef SHIFT_ROTATE_EN
        logic [XLEN-1:0] w_ro;
        assign w_ro = {w_lv[k][S-1:0], w_lv[k][XLEN-1:S]};
        assign w_lv[k+1] = !i_ctl.amt[FIRST+k] ? w_lv[k] : i_ctl.rot ? w_ro : w_sh;
`else
        assign w_lv[k+1] = i_ctl.amt[FIRST+k] ? w_sh : w_lv[k];
`endif
    end

    assign o_ready = !r_v || i_nxt_ready;
    assign o_valid = r_v;
    assign o_ctl   = r_ctl;
    assign o_data  = r_d;

    // payload only loads on a real transfer so a stalled result holds steady
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v   <= 1'b0;
            r_ctl <= '0;
            r_d   <= '0;
        end else if (flush) begin
            r_v <= 1'b0;
        end else if (o_ready) begin
            r_v <= i_valid;
            if (i_valid) begin
                r_ctl <= i_ctl;
                r_d   <= w_lv[LEVELS];
            end
        end
    end
endmodule

// File: rtl/shift_pipe.sv
// shift_pipe: STAGES-deep pipelined barrel shifter (RV64 W and full-width shifts), valid/ready, flush.
// Rotate ops 110/111 are legal only when SHIFT_ROTATE_EN is defined.
module shift_pipe #(
    parameter int XLEN   = 64,
    parameter int STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2:0]                in_op,
    input  logic [XLEN-1:0]           in_src1,
    input  logic [XLEN-1:0]           in_src2,
    input  logic [shift_pkg::TAG_W-1:0] in_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           out_data,
    output logic [shift_pkg::TAG_W-1:0] out_tag,
    output logic                      out_ill
);
    import shift_pkg::*;
    localparam int LG  = $clog2(XLEN);
    localparam int PER = LG / STAGES;
    localparam int REM = LG % STAGES;

    shop_e           w_op;
    shctl_t          w_c0;
    logic [XLEN-1:0] w_lo_s, w_lo_z, w_x, w_xr, w_y, w_yr, w_ysx;
    shctl_t          w_ctl [STAGES+1];
    logic [XLEN-1:0] w_d   [STAGES+1];
    logic            w_v   [STAGES+1];
    logic            w_rdy [STAGES+1];

    assign w_op = shop_e'(in_op);
    if (XLEN > 32) begin : g_wide
        assign w_lo_s = {{(XLEN-32){in_src1[31]}}, in_src1[31:0]};
        assign w_lo_z = {{(XLEN-32){1'b0}}, in_src1[31:0]};
        assign w_ysx  = {{(XLEN-32){w_y[31]}}, w_y[31:0]};
    end else begin : g_narrow
        assign w_lo_s = in_src1;
        assign w_lo_z = in_src1;
        assign w_ysx  = w_y;
    end

    // every op becomes a right shift/rotate; left ops are bit-reversed on entry and exit
    assign w_x  = w_op == SHOP_SRAW ? w_lo_s : w_op == SHOP_SRLW ? w_lo_z : in_src1;
    assign w_xr = {<<{w_x}};
    always_comb begin
        w_c0.tag  = in_tag;
        w_c0.amt  = shop_is_word(w_op) ? SHAMT_W'(in_src2[4:0]) : SHAMT_W'(in_src2[LG-1:0]);
        w_c0.fill = (w_op == SHOP_SRA && in_src1[XLEN-1]) || (w_op == SHOP_SRAW && in_src1[31]);
        w_c0.rot  = w_op inside {SHOP_ROR, SHOP_ROL};
        w_c0.left = w_op inside {SHOP_SLLW, SHOP_SLL, SHOP_ROL};
        w_c0.word = shop_is_word(w_op);
`ifdef SHIFT_ROTATE_EN
        w_c0.ill  = 1'b0;
`else
        w_c0.ill  = w_c0.rot;
`endif
    end

    assign w_ctl[0]      = w_c0;
    assign w_d[0]        = w_c0.left ? w_xr : w_x;
    assign w_v[0]        = in_valid;
    assign w_rdy[STAGES] = out_ready;
    assign in_ready      = w_rdy[0] && !flush;

    for (genvar i = 0; i < STAGES; i++) begin : g_slice
        shift_slice #(
            .XLEN  (XLEN),
            .LEVELS(i == 0 ? PER + REM : PER),
            .FIRST (i == 0 ? 0 : PER + REM + (i - 1) * PER)
        ) u_slice (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush),
            .i_valid    (w_v[i]),
            .i_ctl      (w_ctl[i]),
            .i_data     (w_d[i]),
            .i_nxt_ready(w_rdy[i+1]),
            .o_ready    (w_rdy[i]),
            .o_valid    (w_v[i+1]),
            .o_ctl      (w_ctl[i+1]),
            .o_data     (w_d[i+1])
        );
    end

    assign w_yr      = {<<{w_d[STAGES]}};
    assign w_y       = w_ctl[STAGES].left ? w_yr : w_d[STAGES];
    assign out_valid = w_v[STAGES];
    assign out_tag   = w_ctl[STAGES].tag;
    assign out_ill   = w_ctl[STAGES].ill;
    assign out_data  = w_ctl[STAGES].ill ? '0 : w_ctl[STAGES].word ? w_ysx : w_y;
endmodule
